// File: rtl/stream_upsize.sv
// stream_upsize: packs narrow valid/ready beats into wide words of T_DATA_RATIO lanes.
// Lane 0 carries the first beat of each word; a packet ending mid-word is flushed early.
module stream_upsize #(
    parameter int T_DATA_WIDTH = 1,
    parameter int T_DATA_RATIO = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [T_DATA_WIDTH-1:0] s_data_i,
    input  logic                    s_last_i,
    input  logic                    s_valid_i,
    output logic                    s_ready_o,
    output logic [T_DATA_WIDTH-1:0] m_data_o [T_DATA_RATIO-1:0],
    output logic [T_DATA_RATIO-1:0] m_keep_o,
    output logic                    m_last_o,
    output logic                    m_valid_o,
    input  logic                    m_ready_i
);

    localparam int CW = (T_DATA_RATIO > 1) ? $clog2(T_DATA_RATIO) : 1;
    localparam logic [CW-1:0] LAST_LANE = CW'(T_DATA_RATIO - 1);

    // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
    // valid never waits for ready, and the output word is held while valid & ~ready.

    logic [T_DATA_WIDTH-1:0] r_acc [T_DATA_RATIO-1:0];
    logic [T_DATA_RATIO-1:0] r_mask;
    logic [CW-1:0]           r_cnt;

    logic [T_DATA_WIDTH-1:0] r_m_data [T_DATA_RATIO-1:0];
    logic [T_DATA_RATIO-1:0] r_m_keep;
    logic                    r_m_last;
    logic                    r_m_valid;

    logic                    w_s_ready;
    logic                    w_s_fire;
    logic                    w_m_fire;
    logic                    w_complete;
    logic [T_DATA_WIDTH-1:0] w_word [T_DATA_RATIO-1:0];
    logic [T_DATA_RATIO-1:0] w_keep;

    assign w_s_ready  = ~r_m_valid | m_ready_i;
    assign w_s_fire   = s_valid_i & w_s_ready;
    assign w_m_fire   = r_m_valid & m_ready_i;
    assign w_complete = (r_cnt == LAST_LANE) | s_last_i;
    assign w_keep     = r_mask | (T_DATA_RATIO'(1) << r_cnt);

    // Lanes below the counter come from the accumulator, the current lane takes
    // the incoming beat and lanes above it are zero-filled.
    always_comb begin
        for (int i = 0; i < T_DATA_RATIO; i++) begin
            w_word[i] = '0;
            if (CW'(i) == r_cnt) begin
                w_word[i] = s_data_i;
            end else if (CW'(i) < r_cnt) begin
                w_word[i] = r_acc[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mask <= '0;
            r_cnt  <= '0;
            for (int i = 0; i < T_DATA_RATIO; i++) begin
                r_acc[i] <= '0;
            end
        end else if (w_s_fire) begin
            if (w_complete) begin
                r_mask <= '0;
                r_cnt  <= '0;
            end else begin
                r_acc[r_cnt] <= s_data_i;
                r_mask       <= w_keep;
                r_cnt        <= r_cnt + CW'(1);
            end
        end
    end

    // A completing beat reloads the output even while the held word drains.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
            r_m_keep  <= '0;
            for (int i = 0; i < T_DATA_RATIO; i++) begin
                r_m_data[i] <= '0;
            end
        end else if (w_s_fire && w_complete) begin
            r_m_valid <= 1'b1;
            r_m_last  <= s_last_i;
            r_m_keep  <= w_keep;
            for (int i = 0; i < T_DATA_RATIO; i++) begin
                r_m_data[i] <= w_word[i];
            end
        end else if (w_m_fire) begin
            r_m_valid <= 1'b0;
        end
    end

    assign s_ready_o = w_s_ready;
    assign m_data_o  = r_m_data;
    assign m_keep_o  = r_m_keep;
    assign m_last_o  = r_m_last;
    assign m_valid_o = r_m_valid;

endmodule

// File: tb/tb_stream_upsize.sv
// Bench for stream_upsize: directed tables for R=4/W=8 and R=1/W=4, hand sequences for
// reset and back-pressure, then random traffic against a beat-grouping reference model.
module tb_stream_upsize;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // R=4, W=8 instance
  logic [7:0] s_data8 = '0;
  logic       s_last8 = 1'b0, s_valid8 = 1'b0, s_ready8, m_ready8 = 1'b0;
  logic [7:0] m_data8 [3:0];
  logic [3:0] m_keep8;
  logic       m_last8, m_valid8;

  // R=1, W=4 instance
  logic [3:0] s_data1 = '0;
  logic       s_last1 = 1'b0, s_valid1 = 1'b0, s_ready1, m_ready1 = 1'b0;
  logic [3:0] m_data1 [0:0];
  logic [0:0] m_keep1;
  logic       m_last1, m_valid1;

  stream_upsize #(.T_DATA_WIDTH(8), .T_DATA_RATIO(4)) dut8 (
    .clk(clk), .rst(rst),
    .s_data_i(s_data8), .s_last_i(s_last8), .s_valid_i(s_valid8), .s_ready_o(s_ready8),
    .m_data_o(m_data8), .m_keep_o(m_keep8), .m_last_o(m_last8), .m_valid_o(m_valid8),
    .m_ready_i(m_ready8)
  );

  stream_upsize #(.T_DATA_WIDTH(4), .T_DATA_RATIO(1)) dut1 (
    .clk(clk), .rst(rst),
    .s_data_i(s_data1), .s_last_i(s_last1), .s_valid_i(s_valid1), .s_ready_o(s_ready1),
    .m_data_o(m_data1), .m_keep_o(m_keep1), .m_last_o(m_last1), .m_valid_o(m_valid1),
    .m_ready_i(m_ready1)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: accepted beats are grouped into words of up to 4 beats,
  // closed early by last. Each expected word is {last, keep[3:0], data[31:0]}.
  logic [7:0]  pend_q[$];
  logic [36:0] exp_q[$];
  int          n_exp = 0;
  int          n_got = 0;

  logic        prev_hold = 1'b0;
  logic [36:0] prev_word = '0;
  logic        last_s_fire = 1'b0;
  logic [31:0] flat8;

  function automatic logic [31:0] pack8();
    return {m_data8[3], m_data8[2], m_data8[1], m_data8[0]};
  endfunction

  task automatic step8(input logic rs, input logic v, input logic [7:0] d,
                       input logic l, input logic r);
    logic [36:0] cur;
    logic [31:0] w;
    logic [3:0]  k;
    @(negedge clk);
    rst = rs; s_valid8 = v; s_data8 = d; s_last8 = l; m_ready8 = r;
    #1;
    flat8 = pack8();
    cur = {m_last8, m_keep8, flat8};
    chk("s_ready_rule", {63'd0, s_ready8}, {63'd0, ~m_valid8 | m_ready8});
    if (prev_hold) begin
      chk("hold_valid", {63'd0, m_valid8}, 64'd1);
      chk("hold_word", {27'd0, cur}, {27'd0, prev_word});
    end
    last_s_fire = !rs && v && s_ready8;
    if (!rs && m_valid8 && m_ready8) begin
      n_got++;
      if (exp_q.size() == 0) begin
        chk("unexpected_word", {27'd0, cur}, 64'd0);
      end else begin
        chk("sb_word", {27'd0, cur}, {27'd0, exp_q.pop_front()});
      end
    end
    if (last_s_fire) begin
      pend_q.push_back(d);
      if (pend_q.size() == 4 || l) begin
        w = '0;
        k = '0;
        foreach (pend_q[i]) begin
          w[i*8 +: 8] = pend_q[i];
          k[i] = 1'b1;
        end
        exp_q.push_back({l, k, w});
        n_exp++;
        pend_q.delete();
      end
    end
    prev_hold = !rs && m_valid8 && !m_ready8;
    prev_word = cur;
    if (rs) begin
      n_exp = n_exp - exp_q.size();
      exp_q.delete();
      pend_q.delete();
    end
  endtask

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       l;
    logic       r;
    logic       ev;
    logic [31:0] ed;
    logic [3:0] ek;
    logic       el;
    logic       es;
  } vec8_t;

  typedef struct {
    logic       v;
    logic [3:0] d;
    logic       l;
    logic       r;
    logic       ev;
    logic [3:0] ed;
    logic       el;
    logic       es;
  } vec1_t;

  function automatic vec8_t mk8(input logic v, input logic [7:0] d, input logic l,
                                input logic ev, input logic [31:0] ed,
                                input logic [3:0] ek, input logic el);
    vec8_t t;
    t.v = v; t.d = d; t.l = l; t.r = 1'b1;
    t.ev = ev; t.ed = ed; t.ek = ek; t.el = el; t.es = 1'b1;
    return t;
  endfunction

  function automatic vec1_t mk1(input logic v, input logic [3:0] d, input logic l,
                                input logic r, input logic ev, input logic [3:0] ed,
                                input logic el, input logic es);
    vec1_t t;
    t.v = v; t.d = d; t.l = l; t.r = r;
    t.ev = ev; t.ed = ed; t.el = el; t.es = es;
    return t;
  endfunction

  task automatic step1(input vec1_t t);
    @(negedge clk);
    rst = 1'b0; s_valid1 = t.v; s_data1 = t.d; s_last1 = t.l; m_ready1 = t.r;
    #1;
    chk("r1_valid", {63'd0, m_valid1}, {63'd0, t.ev});
    chk("r1_s_ready", {63'd0, s_ready1}, {63'd0, t.es});
    if (t.ev) begin
      chk("r1_data", {60'd0, m_data1[0]}, {60'd0, t.ed});
      chk("r1_keep", {63'd0, m_keep1}, 64'd1);
      chk("r1_last", {63'd0, m_last1}, {63'd0, t.el});
    end
  endtask

  vec8_t tab8[17];
  vec1_t tab1[8];

  initial begin
    int b;
    int cyc;
    logic [7:0] rd;

    tab8[0]  = mk8(1, 8'h01, 0, 0, 32'h0, 4'h0, 0);
    tab8[1]  = mk8(1, 8'h02, 0, 0, 32'h0, 4'h0, 0);
    tab8[2]  = mk8(1, 8'h03, 0, 0, 32'h0, 4'h0, 0);
    tab8[3]  = mk8(1, 8'h04, 0, 0, 32'h0, 4'h0, 0);
    tab8[4]  = mk8(1, 8'h05, 0, 1, 32'h04030201, 4'hF, 0);
    tab8[5]  = mk8(1, 8'h06, 0, 0, 32'h0, 4'h0, 0);
    tab8[6]  = mk8(1, 8'h07, 0, 0, 32'h0, 4'h0, 0);
    tab8[7]  = mk8(1, 8'h08, 1, 0, 32'h0, 4'h0, 0);
    tab8[8]  = mk8(1, 8'hA0, 0, 1, 32'h08070605, 4'hF, 1);
    tab8[9]  = mk8(1, 8'hA1, 0, 0, 32'h0, 4'h0, 0);
    tab8[10] = mk8(1, 8'hA2, 0, 0, 32'h0, 4'h0, 0);
    tab8[11] = mk8(1, 8'hA3, 0, 0, 32'h0, 4'h0, 0);
    tab8[12] = mk8(1, 8'hA4, 0, 1, 32'hA3A2A1A0, 4'hF, 0);
    tab8[13] = mk8(1, 8'hA5, 1, 0, 32'h0, 4'h0, 0);
    tab8[14] = mk8(1, 8'h5C, 1, 1, 32'h0000A5A4, 4'h3, 1);
    tab8[15] = mk8(0, 8'h00, 0, 1, 32'h0000005C, 4'h1, 1);
    tab8[16] = mk8(0, 8'h00, 0, 0, 32'h0, 4'h0, 0);

    tab1[0] = mk1(1, 4'h3, 0, 1, 0, 4'h0, 0, 1);
    tab1[1] = mk1(1, 4'h9, 1, 1, 1, 4'h3, 0, 1);
    tab1[2] = mk1(0, 4'h0, 0, 1, 1, 4'h9, 1, 1);
    tab1[3] = mk1(1, 4'h6, 0, 0, 0, 4'h0, 0, 1);
    tab1[4] = mk1(1, 4'h7, 0, 0, 1, 4'h6, 0, 0);
    tab1[5] = mk1(1, 4'h7, 1, 1, 1, 4'h6, 0, 1);
    tab1[6] = mk1(0, 4'h0, 0, 1, 1, 4'h7, 1, 1);
    tab1[7] = mk1(0, 4'h0, 0, 1, 0, 4'h0, 0, 1);

    // Reset and reset values
    step8(1, 0, 8'h00, 0, 0);
    step8(1, 0, 8'h00, 0, 0);
    step8(0, 0, 8'h00, 0, 0);
    chk("rst_valid8", {63'd0, m_valid8}, 64'd0);
    chk("rst_keep8", {60'd0, m_keep8}, 64'd0);
    chk("rst_last8", {63'd0, m_last8}, 64'd0);
    chk("rst_data8", {32'd0, flat8}, 64'd0);
    chk("rst_s_ready8", {63'd0, s_ready8}, 64'd1);
    chk("rst_valid1", {63'd0, m_valid1}, 64'd0);
    chk("rst_keep1", {63'd0, m_keep1}, 64'd0);

    // R=1 register slice
    foreach (tab1[i]) step1(tab1[i]);

    // R=4 directed packets: 8 beats, 6 beats, single beat
    foreach (tab8[i]) begin
      step8(0, tab8[i].v, tab8[i].d, tab8[i].l, tab8[i].r);
      chk($sformatf("t8_valid_%0d", i), {63'd0, m_valid8}, {63'd0, tab8[i].ev});
      chk($sformatf("t8_s_ready_%0d", i), {63'd0, s_ready8}, {63'd0, tab8[i].es});
      if (tab8[i].ev) begin
        chk($sformatf("t8_data_%0d", i), {32'd0, flat8}, {32'd0, tab8[i].ed});
        chk($sformatf("t8_keep_%0d", i), {60'd0, m_keep8}, {60'd0, tab8[i].ek});
        chk($sformatf("t8_last_%0d", i), {63'd0, m_last8}, {63'd0, tab8[i].el});
      end
    end

    // Reset after 2 beats of a word; next packet restarts at lane 0
    step8(0, 1, 8'h31, 0, 1);
    step8(0, 1, 8'h32, 0, 1);
    step8(1, 0, 8'h00, 0, 0);
    step8(0, 0, 8'h00, 0, 1);
    chk("rstmid_valid", {63'd0, m_valid8}, 64'd0);
    chk("rstmid_keep", {60'd0, m_keep8}, 64'd0);
    step8(0, 1, 8'h41, 0, 1);
    step8(0, 1, 8'h42, 0, 1);
    step8(0, 1, 8'h43, 1, 1);
    step8(0, 0, 8'h00, 0, 0);
    chk("after_rst_valid", {63'd0, m_valid8}, 64'd1);
    chk("after_rst_data", {32'd0, flat8}, 64'h00434241);
    chk("after_rst_keep", {60'd0, m_keep8}, 64'h7);
    chk("after_rst_last", {63'd0, m_last8}, 64'd1);
    step8(0, 0, 8'h00, 0, 1);

    // Reset with a held output word
    for (int i = 0; i < 4; i++) step8(0, 1, 8'h51 + 8'(i), 0, 0);
    step8(0, 0, 8'h00, 0, 0);
    chk("held_valid", {63'd0, m_valid8}, 64'd1);
    step8(1, 0, 8'h00, 0, 0);
    step8(0, 0, 8'h00, 0, 1);
    chk("rsthold_valid", {63'd0, m_valid8}, 64'd0);
    chk("rsthold_keep", {60'd0, m_keep8}, 64'd0);

    // 16-beat stream with the first word held by back-pressure, then released
    b = 0;
    cyc = 0;
    while (b < 16 && cyc < 200) begin
      step8(0, 1, 8'h10 + 8'(b), (b == 15), (cyc >= 12));
      if (cyc >= 4 && cyc < 12) begin
        chk("stall_s_ready", {63'd0, s_ready8}, 64'd0);
      end
      if (cyc == 8) begin
        chk("stall_word", {27'd0, m_last8, m_keep8, flat8}, {27'd0, 1'b0, 4'hF, 32'h13121110});
      end
      if (last_s_fire) b++;
      cyc++;
    end
    chk("stall_beats", 64'(b), 64'd16);
    chk("stall_cycles", 64'(cyc), 64'd24);
    for (int i = 0; i < 3; i++) step8(0, 0, 8'h00, 0, 1);
    chk("stall_drained", 64'(exp_q.size()), 64'd0);

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      rd = 8'($urandom);
      step8(0, ($urandom_range(0, 3) != 0), rd, ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 3) != 0));
    end
    cyc = 0;
    last_s_fire = 1'b0;
    while (!last_s_fire && cyc < 50) begin
      step8(0, 1, 8'hEE, 1, ($urandom_range(0, 1) == 1));
      cyc++;
    end
    chk("final_beat_accepted", {63'd0, last_s_fire}, 64'd1);
    for (int i = 0; i < 4; i++) step8(0, 0, 8'h00, 0, 1);
    chk("rand_exp_empty", 64'(exp_q.size()), 64'd0);
    chk("rand_word_count", 64'(n_got), 64'(n_exp));
    chk("rand_valid_idle", {63'd0, m_valid8}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
